// File: rtl/pipelined_subtractor_if.sv
// Handshake and data bundle for the four-stage pipelined subtractor.
// The slave modport is the subtractor. The master modport is whoever feeds
// operands and consumes results.
interface pipelined_subtractor_if;
  logic        InValid;
  logic        InReady;
  logic [31:0] A;
  logic [31:0] B;
  logic        BI;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] D;
  logic        BO;
  logic        OV;

  modport master (
    output InValid, A, B, BI, OutReady,
    input  InReady, OutValid, D, BO, OV
  );

  modport slave (
    input  InValid, A, B, BI, OutReady,
    output InReady, OutValid, D, BO, OV
  );
endinterface

// File: rtl/pipelined_subtractor.sv
// Four-stage pipelined 32-bit subtractor: D = A - B - BI.
// An input register captures each accepted operation. Stages 0..3 then each
// resolve one byte, LSB first, as A + ~B + carry, and register the carry for
// the next slice. Borrow-out is the inverse of the final carry.
// A single advance signal stalls every register at once. This lets a
// downstream consumer apply backpressure without dropping or reordering work.
module pipelined_subtractor (
  input logic                   Clock,
  input logic                   Reset_n,
  pipelined_subtractor_if.slave bus
);

  // Global advance: the pipeline moves when the output slot is free or being drained
  logic adv;

  // Input register: raw operands of the accepted operation
  logic        in_v_q,   in_v_d;
  logic [31:0] in_a_q,   in_a_d;
  logic [31:0] in_b_q,   in_b_d;
  logic        in_bi_q,  in_bi_d;

  // Stage 0..2 registers carry only the operand bits that are still unconsumed.
  // Low operand bits have no reader once their slice is resolved, so they are not kept.
  logic        s0_v_q,   s0_v_d;
  logic [31:8] s0_a_q,   s0_a_d;
  logic [31:8] s0_b_q,   s0_b_d;
  logic [7:0]  s0_dif_q, s0_dif_d;
  logic        s0_c_q,   s0_c_d;

  logic        s1_v_q,   s1_v_d;
  logic [31:16] s1_a_q,  s1_a_d;
  logic [31:16] s1_b_q,  s1_b_d;
  logic [15:0] s1_dif_q, s1_dif_d;
  logic        s1_c_q,   s1_c_d;

  logic        s2_v_q,   s2_v_d;
  logic [31:24] s2_a_q,  s2_a_d;
  logic [31:24] s2_b_q,  s2_b_d;
  logic [23:0] s2_dif_q, s2_dif_d;
  logic        s2_c_q,   s2_c_d;

  // Stage 3 register is the output register
  logic        s3_v_q,   s3_v_d;
  logic [31:0] s3_dif_q, s3_dif_d;
  logic        s3_bo_q,  s3_bo_d;
  logic        s3_ov_q,  s3_ov_d;

  // Per-slice sums: bit 8 is the carry out of the slice
  logic [8:0]  sum0_s;
  logic [8:0]  sum1_s;
  logic [8:0]  sum2_s;
  logic [8:0]  sum3_s;

  assign adv          = !s3_v_q || bus.OutReady;
  assign bus.InReady  = adv;
  assign bus.OutValid = s3_v_q;
  assign bus.D        = s3_dif_q;
  assign bus.BO       = s3_bo_q;
  assign bus.OV       = s3_ov_q;

  // Slice arithmetic: each byte is A + ~B + carry-in, with stage 0 seeded by ~BI
  always_comb begin
    sum0_s = {1'b0, in_a_q[7:0]}   + {1'b0, ~in_b_q[7:0]}   + {8'd0, ~in_bi_q};
    sum1_s = {1'b0, s0_a_q[15:8]}  + {1'b0, ~s0_b_q[15:8]}  + {8'd0, s0_c_q};
    sum2_s = {1'b0, s1_a_q[23:16]} + {1'b0, ~s1_b_q[23:16]} + {8'd0, s1_c_q};
    sum3_s = {1'b0, s2_a_q[31:24]} + {1'b0, ~s2_b_q[31:24]} + {8'd0, s2_c_q};
  end

  // Next-state: every register loads from its predecessor on advance, otherwise holds
  always_comb begin
    in_v_d   = in_v_q;   in_a_d   = in_a_q;   in_b_d   = in_b_q;   in_bi_d = in_bi_q;
    s0_v_d   = s0_v_q;   s0_a_d   = s0_a_q;   s0_b_d   = s0_b_q;
    s0_dif_d = s0_dif_q; s0_c_d   = s0_c_q;
    s1_v_d   = s1_v_q;   s1_a_d   = s1_a_q;   s1_b_d   = s1_b_q;
    s1_dif_d = s1_dif_q; s1_c_d   = s1_c_q;
    s2_v_d   = s2_v_q;   s2_a_d   = s2_a_q;   s2_b_d   = s2_b_q;
    s2_dif_d = s2_dif_q; s2_c_d   = s2_c_q;
    s3_v_d   = s3_v_q;   s3_dif_d = s3_dif_q; s3_bo_d  = s3_bo_q;  s3_ov_d = s3_ov_q;
    if (adv) begin
      // A cycle without InValid inserts a bubble; its data is don't-care
      in_v_d   = bus.InValid;
      in_a_d   = bus.A;
      in_b_d   = bus.B;
      in_bi_d  = bus.BI;

      s0_v_d   = in_v_q;
      s0_a_d   = in_a_q[31:8];
      s0_b_d   = in_b_q[31:8];
      s0_dif_d = sum0_s[7:0];
      s0_c_d   = sum0_s[8];

      s1_v_d   = s0_v_q;
      s1_a_d   = s0_a_q[31:16];
      s1_b_d   = s0_b_q[31:16];
      s1_dif_d = {sum1_s[7:0], s0_dif_q};
      s1_c_d   = sum1_s[8];

      s2_v_d   = s1_v_q;
      s2_a_d   = s1_a_q[31:24];
      s2_b_d   = s1_b_q[31:24];
      s2_dif_d = {sum2_s[7:0], s1_dif_q};
      s2_c_d   = sum2_s[8];

      s3_v_d   = s2_v_q;
      s3_dif_d = {sum3_s[7:0], s2_dif_q};
      s3_bo_d  = ~sum3_s[8];
      // Overflow: operand signs differ and result sign differs from the minuend
      s3_ov_d  = (s2_a_q[31] != s2_b_q[31]) && (sum3_s[7] != s2_a_q[31]);
    end else begin
      // Stalled: all defaults above already hold the current contents
      in_v_d   = in_v_q;
    end
  end

  // State registers: asynchronous clear discards everything in flight
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      in_v_q   <= 1'b0;   in_a_q   <= 32'd0;  in_b_q   <= 32'd0;  in_bi_q <= 1'b0;
      s0_v_q   <= 1'b0;   s0_a_q   <= 24'd0;  s0_b_q   <= 24'd0;
      s0_dif_q <= 8'd0;   s0_c_q   <= 1'b0;
      s1_v_q   <= 1'b0;   s1_a_q   <= 16'd0;  s1_b_q   <= 16'd0;
      s1_dif_q <= 16'd0;  s1_c_q   <= 1'b0;
      s2_v_q   <= 1'b0;   s2_a_q   <= 8'd0;   s2_b_q   <= 8'd0;
      s2_dif_q <= 24'd0;  s2_c_q   <= 1'b0;
      s3_v_q   <= 1'b0;   s3_dif_q <= 32'd0;  s3_bo_q  <= 1'b0;   s3_ov_q <= 1'b0;
    end else begin
      in_v_q   <= in_v_d;   in_a_q   <= in_a_d;   in_b_q   <= in_b_d;   in_bi_q <= in_bi_d;
      s0_v_q   <= s0_v_d;   s0_a_q   <= s0_a_d;   s0_b_q   <= s0_b_d;
      s0_dif_q <= s0_dif_d; s0_c_q   <= s0_c_d;
      s1_v_q   <= s1_v_d;   s1_a_q   <= s1_a_d;   s1_b_q   <= s1_b_d;
      s1_dif_q <= s1_dif_d; s1_c_q   <= s1_c_d;
      s2_v_q   <= s2_v_d;   s2_a_q   <= s2_a_d;   s2_b_q   <= s2_b_d;
      s2_dif_q <= s2_dif_d; s2_c_q   <= s2_c_d;
      s3_v_q   <= s3_v_d;   s3_dif_q <= s3_dif_d; s3_bo_q  <= s3_bo_d;  s3_ov_q <= s3_ov_d;
    end
  end

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Self-checking bench for pipelined_subtractor.
// A queue-based reference model records every accepted operation as
// A - B - BI in 33 bits. A single negedge process compares each valid
// output against the head of the queue.
module tb_pipelined_subtractor;
  logic Clock   = 1'b0;
  logic Reset_n = 1'b1;

  pipelined_subtractor_if bus ();

  pipelined_subtractor dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  int popped = 0;
  logic [33:0] exp_q[$];   // {D, BO, OV} in acceptance order

  // Reference: 33-bit subtraction, borrow is bit 32, overflow from operand/result signs
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic bi);
    logic [32:0] r;
    logic        ov;
    r  = {1'b0, a} - {1'b0, b} - {32'd0, bi};
    ov = (a[31] != b[31]) && (r[31] != a[31]);
    return {r[31:0], r[32], ov};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Compare process: checks outputs and handshake, then updates the scoreboard for the coming edge
  always @(negedge Clock) begin
    if (Reset_n) begin
      chk("in_ready_rule", bus.InReady, !bus.OutValid || bus.OutReady);
      if (bus.OutValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual D=%0h required none", bus.D);
        end else begin
          chk("D",  bus.D,  exp_q[0][33:2]);
          chk("BO", bus.BO, exp_q[0][1]);
          chk("OV", bus.OV, exp_q[0][0]);
          if (bus.OutReady) begin
            void'(exp_q.pop_front());
            popped++;
          end
        end
      end
      if (bus.InValid && bus.InReady) exp_q.push_back(model(bus.A, bus.B, bus.BI));
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic bi);
    @(posedge Clock); #2;
    bus.InValid = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.BI = bi;
  endtask

  initial begin
    int lat;
    int idx;
    int issued;
    int base;
    logic acc;
    logic saw_low;
    logic [31:0] held;

    bus.InValid = 1'b0; bus.A = 32'd0; bus.B = 32'd0; bus.BI = 1'b0; bus.OutReady = 1'b1;

    // Reset: outputs clear without any clock edge
    #1 Reset_n = 1'b0;
    #1;
    chk("rst_outvalid", bus.OutValid, 1'b0);
    chk("rst_d",        bus.D,        32'd0);
    chk("rst_bo",       bus.BO,       1'b0);
    chk("rst_ov",       bus.OV,       1'b0);
    repeat (3) begin
      @(posedge Clock); #2;
      bus.InValid = 1'b1; bus.A = $urandom; bus.B = $urandom; bus.BI = 1'($urandom_range(0, 1));
    end
    @(negedge Clock);
    chk("rst_hold_outvalid", bus.OutValid, 1'b0);
    chk("rst_hold_d",        bus.D,        32'd0);

    // Pin the model with hand-computed results
    chk("model_cross_slice", model(32'h0000_0100, 32'h0000_0001, 1'b0), {32'h0000_00FF, 1'b0, 1'b0});
    chk("model_ripple",      model(32'h0000_0000, 32'h0000_0001, 1'b0), {32'hFFFF_FFFF, 1'b1, 1'b0});
    chk("model_eq_bi",       model(32'h1234_5678, 32'h1234_5678, 1'b1), {32'hFFFF_FFFF, 1'b1, 1'b0});
    chk("model_ovf_neg",     model(32'h8000_0000, 32'h0000_0001, 1'b0), {32'h7FFF_FFFF, 1'b0, 1'b1});
    chk("model_ovf_pos",     model(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0), {32'h8000_0000, 1'b1, 1'b1});
    chk("model_bp3",         model(32'h0303_0303, 32'h0000_0003, 1'b0), {32'h0303_0300, 1'b0, 1'b0});

    // Release reset with an operation already presented: the first edge accepts it
    @(posedge Clock); #2;
    Reset_n = 1'b1;
    bus.InValid = 1'b1; bus.A = 32'h0000_0100; bus.B = 32'h0000_0001; bus.BI = 1'b0;
    #1 chk("inready_after_reset", bus.InReady, 1'b1);
    @(posedge Clock); #2;
    bus.InValid = 1'b0;
    lat = 0;
    while (!bus.OutValid && lat < 10) begin
      @(posedge Clock); #1;
      lat++;
    end
    chk("latency",   lat,     4);
    chk("lat_d",     bus.D,   32'h0000_00FF);
    chk("lat_bo",    bus.BO,  1'b0);
    chk("lat_ov",    bus.OV,  1'b0);

    // Directed corner vectors, back to back
    send(32'h0000_0000, 32'h0000_0001, 1'b0);
    send(32'h1234_5678, 32'h1234_5678, 1'b1);
    send(32'h8000_0000, 32'h0000_0001, 1'b0);
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    send(32'h8000_0000, 32'h0000_0000, 1'b1);
    @(posedge Clock); #2;
    bus.InValid = 1'b0;
    repeat (8) @(posedge Clock);
    chk("directed_drained", exp_q.size(), 0);

    // Backpressure: six back-to-back operations, consumer stalls cycles 5..9
    base = popped; idx = 0; acc = 1'b0; saw_low = 1'b0; held = 32'd0;
    for (int c = 0; c < 30; c++) begin
      @(posedge Clock); #2;
      if (acc) idx++;
      bus.OutReady = !(c >= 5 && c <= 9);
      if (idx < 6) begin
        bus.InValid = 1'b1;
        bus.A = 32'(idx + 1) * 32'h0101_0101;
        bus.B = 32'(idx + 1);
        bus.BI = 1'b0;
      end else begin
        bus.InValid = 1'b0;
      end
      @(negedge Clock);
      acc = bus.InValid && bus.InReady;
      if (bus.OutValid && !bus.OutReady && !bus.InReady) saw_low = 1'b1;
      if (c == 5) held = bus.D;
      if (c == 9) chk("bp_d_stable", bus.D, held);
    end
    chk("bp_inready_dropped", saw_low, 1'b1);
    chk("bp_result_count", popped - base, 6);
    chk("bp_drained", exp_q.size(), 0);

    // Random stream with bubbles, stalls and one mid-stream reset
    issued = 0; acc = 1'b0;
    for (int cyc = 0; cyc < 40000 && issued < 10000; cyc++) begin
      @(posedge Clock); #2;
      if (acc) issued++;
      if (cyc == 3006) begin
        chk("pre_reset_valid", bus.OutValid, 1'b1);
        Reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_outvalid", bus.OutValid, 1'b0);
        chk("midrst_d",        bus.D,        32'd0);
        chk("midrst_bo",       bus.BO,       1'b0);
        chk("midrst_ov",       bus.OV,       1'b0);
        @(posedge Clock); #2;
        Reset_n = 1'b1;
        #1 chk("midrst_inready", bus.InReady, 1'b1);
      end
      bus.InValid = ($urandom_range(0, 9) < 7) || (cyc >= 3000 && cyc < 3006);
      bus.OutReady = ($urandom_range(0, 9) < 7) && !(cyc >= 3000 && cyc < 3006);
      bus.A = pick();
      bus.B = pick();
      bus.BI = 1'($urandom_range(0, 1));
      @(negedge Clock);
      acc = bus.InValid && bus.InReady && Reset_n;
    end
    chk("random_ops_done", issued >= 10000, 1'b1);
    @(posedge Clock); #2;
    bus.InValid = 1'b0;
    bus.OutReady = 1'b1;
    repeat (10) @(posedge Clock);
    #1 chk("random_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
